// File: rtl/wb_gpio_bank.sv
// ----------------------------------------------------------------------------
// wb_gpio_bank
//
// Wishbone classic slave GPIO bank with per-pin edge interrupts.
//
// Parameters
//   NUM_GPIO   number of GPIO channels (1..32)
//   BASE_ADDR  Wishbone base address, 64-byte aligned
//   DBNC_DIV   debounce tick divisor in clocks (2..65535), only used when
//              the GPIO_DEBOUNCE_EN macro is defined
//
// Optional feature
//   GPIO_DEBOUNCE_EN  adds a tick-based input debouncer and the DBNC_BYPASS
//                     register at offset 0x20. Undefined by default.
//
// Ports
//   wb_clk_i            clock
//   wb_rst_i            synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i Wishbone classic slave controls
//   wbs_sel_i[3:0]      byte enables
//   wbs_adr_i[31:0]     address
//   wbs_dat_i[31:0]     write data
//   wbs_ack_o           acknowledge (one cycle, never back-to-back)
//   wbs_dat_o[31:0]     read data (valid with ack, 0 otherwise)
//   gpio_in             asynchronous pad inputs
//   gpio_out            pad output data
//   gpio_oeb            active-low pad output enable
//   irq                 level interrupt
//
// Register map (index = wbs_adr_i[5:2])
//   0x00 DATA_OUT    rw
//   0x04 OE          rw   gpio_oeb = ~OE
//   0x08 DATA_IN     ro
//   0x0C IRQ_EN      rw
//   0x10 IRQ_RISE    rw
//   0x14 IRQ_FALL    rw
//   0x18 IRQ_STATUS  write-1-to-clear
//   0x1C OUT_TOGGLE  wo   XOR into DATA_OUT, reads 0
//   0x20 DBNC_BYPASS rw   (GPIO_DEBOUNCE_EN only)
// ----------------------------------------------------------------------------
module wb_gpio_bank #(
    parameter int unsigned NUM_GPIO  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned DBNC_DIV  = 1000
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic [NUM_GPIO-1:0] gpio_in,
    output logic [NUM_GPIO-1:0] gpio_out,
    output logic [NUM_GPIO-1:0] gpio_oeb,
    output logic                irq
);

    localparam logic [3:0] IDX_DATA_OUT   = 4'h0;
    localparam logic [3:0] IDX_OE         = 4'h1;
    localparam logic [3:0] IDX_DATA_IN    = 4'h2;
    localparam logic [3:0] IDX_IRQ_EN     = 4'h3;
    localparam logic [3:0] IDX_IRQ_RISE   = 4'h4;
    localparam logic [3:0] IDX_IRQ_FALL   = 4'h5;
    localparam logic [3:0] IDX_IRQ_STATUS = 4'h6;
    localparam logic [3:0] IDX_OUT_TOGGLE = 4'h7;
`ifdef GPIO_DEBOUNCE_EN
    localparam logic [3:0] IDX_DBNC_BYP   = 4'h8;
`endif

    logic                r_ack;
    logic [31:0]         r_dat;
    logic [NUM_GPIO-1:0] r_data_out;
    logic [NUM_GPIO-1:0] r_oe;
    logic [NUM_GPIO-1:0] r_irq_en;
    logic [NUM_GPIO-1:0] r_irq_rise;
    logic [NUM_GPIO-1:0] r_irq_fall;
    logic [NUM_GPIO-1:0] r_irq_status;
    logic [NUM_GPIO-1:0] r_sync1;
    logic [NUM_GPIO-1:0] r_sync2;
    logic [NUM_GPIO-1:0] r_data_in_prev;
    logic                r_irq;

    logic                w_sel;
    logic                w_req;
    logic                w_wr;
    logic [3:0]          w_idx;
    logic [31:0]         w_bmask;
    logic [NUM_GPIO-1:0] w_wmask;
    logic [NUM_GPIO-1:0] w_wbits;
    logic [NUM_GPIO-1:0] w_data_in;
    logic [NUM_GPIO-1:0] w_event;
    logic [NUM_GPIO-1:0] w_clr;
    logic [NUM_GPIO-1:0] w_rdata_n;
    logic [31:0]         w_rdata;
    logic                w_unused;

    // ------------------------------------------------------------------
    // Bus decode. A request is only taken when no ack is pending, which
    // spaces acks of a held strobe to every second cycle.
    // ------------------------------------------------------------------
    assign w_sel   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:6] == BASE_ADDR[31:6]);
    assign w_req   = w_sel & ~r_ack;
    assign w_wr    = w_req & wbs_we_i;
    assign w_idx   = wbs_adr_i[5:2];
    assign w_bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                      {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign w_wmask = w_bmask[NUM_GPIO-1:0];
    assign w_wbits = wbs_dat_i[NUM_GPIO-1:0] & w_wmask;

    function automatic logic [NUM_GPIO-1:0] f_merge(
        input logic [NUM_GPIO-1:0] old_val,
        input logic [NUM_GPIO-1:0] bits,
        input logic [NUM_GPIO-1:0] mask
    );
        return (old_val & ~mask) | bits;
    endfunction

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    // ------------------------------------------------------------------
    // Debouncer: a down-counter ticks at terminal count every DBNC_DIV
    // clocks. On each tick the synchronized pin is sampled; a pin's
    // debounced value follows only when the current and two previous tick
    // samples agree. Resetting history to 0 matches the cleared DATA_IN.
    // ------------------------------------------------------------------
    logic [15:0]         r_tick_cnt;
    logic [NUM_GPIO-1:0] r_dbnc_h0;
    logic [NUM_GPIO-1:0] r_dbnc_h1;
    logic [NUM_GPIO-1:0] r_dbnc;
    logic [NUM_GPIO-1:0] r_dbnc_byp;
    logic                w_tick;
    logic [NUM_GPIO-1:0] w_stable;

    assign w_tick   = (r_tick_cnt == 16'd0);
    assign w_stable = ~(r_sync2 ^ r_dbnc_h0) & ~(r_dbnc_h0 ^ r_dbnc_h1);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_tick_cnt <= 16'(DBNC_DIV - 1);
            r_dbnc_h0  <= '0;
            r_dbnc_h1  <= '0;
            r_dbnc     <= '0;
            r_dbnc_byp <= '0;
        end else begin
            if (w_tick) begin
                r_tick_cnt <= 16'(DBNC_DIV - 1);
                r_dbnc_h0  <= r_sync2;
                r_dbnc_h1  <= r_dbnc_h0;
                r_dbnc     <= (r_dbnc & ~w_stable) | (r_sync2 & w_stable);
            end else begin
                r_tick_cnt <= r_tick_cnt - 16'd1;
            end
            if (w_wr && (w_idx == IDX_DBNC_BYP)) begin
                r_dbnc_byp <= f_merge(r_dbnc_byp, w_wbits, w_wmask);
            end
        end
    end

    assign w_data_in = (r_dbnc_byp & r_sync2) | (~r_dbnc_byp & r_dbnc);
    assign w_unused  = ^{1'b0, wbs_adr_i[1:0], wbs_dat_i, w_bmask};
`else
    logic [31:0] w_dbnc_div_unused;

    assign w_dbnc_div_unused = 32'(DBNC_DIV);
    assign w_data_in         = r_sync2;
    assign w_unused          = ^{1'b0, wbs_adr_i[1:0], wbs_dat_i, w_bmask,
                                 w_dbnc_div_unused};
`endif

    // ------------------------------------------------------------------
    // Edge events are evaluated against the registers as they stand
    // before this edge, so a same-cycle write to IRQ_RISE/IRQ_FALL only
    // affects later samples.
    // ------------------------------------------------------------------
    assign w_event = (r_irq_rise & w_data_in & ~r_data_in_prev) |
                     (r_irq_fall & ~w_data_in & r_data_in_prev);
    assign w_clr   = (w_wr && (w_idx == IDX_IRQ_STATUS)) ? w_wbits : '0;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata_n = '0;
        case (w_idx)
            IDX_DATA_OUT:   w_rdata_n = r_data_out;
            IDX_OE:         w_rdata_n = r_oe;
            IDX_DATA_IN:    w_rdata_n = w_data_in;
            IDX_IRQ_EN:     w_rdata_n = r_irq_en;
            IDX_IRQ_RISE:   w_rdata_n = r_irq_rise;
            IDX_IRQ_FALL:   w_rdata_n = r_irq_fall;
            IDX_IRQ_STATUS: w_rdata_n = r_irq_status;
            IDX_OUT_TOGGLE: w_rdata_n = '0;
`ifdef GPIO_DEBOUNCE_EN
            IDX_DBNC_BYP:   w_rdata_n = r_dbnc_byp;
`endif
            default:        w_rdata_n = '0;
        endcase
    end

    always_comb begin
        w_rdata                = '0;
        w_rdata[NUM_GPIO-1:0]  = w_rdata_n;
    end

    // ------------------------------------------------------------------
    // Bus registers, control registers and interrupt state
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack          <= 1'b0;
            r_dat          <= '0;
            r_data_out     <= '0;
            r_oe           <= '0;
            r_irq_en       <= '0;
            r_irq_rise     <= '0;
            r_irq_fall     <= '0;
            r_irq_status   <= '0;
            r_data_in_prev <= '0;
            r_irq          <= 1'b0;
        end else begin
            r_ack <= w_req;
            r_dat <= w_req ? w_rdata : '0;
            if (w_wr) begin
                case (w_idx)
                    IDX_DATA_OUT:   r_data_out <= f_merge(r_data_out, w_wbits, w_wmask);
                    IDX_OE:         r_oe       <= f_merge(r_oe, w_wbits, w_wmask);
                    IDX_IRQ_EN:     r_irq_en   <= f_merge(r_irq_en, w_wbits, w_wmask);
                    IDX_IRQ_RISE:   r_irq_rise <= f_merge(r_irq_rise, w_wbits, w_wmask);
                    IDX_IRQ_FALL:   r_irq_fall <= f_merge(r_irq_fall, w_wbits, w_wmask);
                    IDX_OUT_TOGGLE: r_data_out <= r_data_out ^ w_wbits;
                    default: ;
                endcase
            end
            // new events override a simultaneous clear
            r_irq_status   <= (r_irq_status & ~w_clr) | w_event;
            r_data_in_prev <= w_data_in;
            r_irq          <= |(r_irq_status & r_irq_en);
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign gpio_out  = r_data_out;
    assign gpio_oeb  = ~r_oe;
    assign irq       = r_irq;

endmodule

// File: tb/tb_wb_gpio_bank.sv
module tb_wb_gpio_bank;

    localparam int          N    = 8;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          DIV  = 4;
    localparam logic [31:0] MSK  = 32'h0000_00FF;

    logic         clk;
    logic         rst;
    logic         cyc, stb, we;
    logic [3:0]   sel;
    logic [31:0]  adr, dat_w;
    logic         ack;
    logic [31:0]  dat_r;
    logic [N-1:0] gpio_in;
    logic [N-1:0] gpio_out;
    logic [N-1:0] gpio_oeb;
    logic         irq;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    wb_gpio_bank #(
        .NUM_GPIO (N),
        .BASE_ADDR(BASE),
        .DBNC_DIV (DIV)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat_w),
        .wbs_ack_o(ack),
        .wbs_dat_o(dat_r),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oeb (gpio_oeb),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: register file as plain 32-bit words, pin history as
    // a two-deep delay line, debounce as a count of agreeing tick samples.
    // ------------------------------------------------------------------
    logic [31:0] m_out, m_oe, m_en, m_rise, m_fall, m_stat;
    logic [31:0] m_din_prev, m_pin_new, m_pin_old, m_dat, m_byp, m_db, m_last;
    logic        m_ack, m_irq;
    int          m_ticks;
    int          m_run [N];

    function automatic logic [31:0] bytes_of(input logic [3:0] s);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = 8'hFF;
        return r;
    endfunction

    function automatic logic [31:0] cur_din();
`ifdef GPIO_DEBOUNCE_EN
        return (m_byp & m_pin_old) | (~m_byp & m_db);
`else
        return m_pin_old;
`endif
    endfunction

    task automatic model_step();
        logic [31:0] din, ev, rd, bm, wd, clr;
        logic        irq_n;
        logic [3:0]  idx;
        if (rst) begin
            m_out = '0; m_oe = '0; m_en = '0; m_rise = '0; m_fall = '0; m_stat = '0;
            m_din_prev = '0; m_pin_new = '0; m_pin_old = '0; m_dat = '0;
            m_byp = '0; m_db = '0; m_last = '0; m_ack = 1'b0; m_irq = 1'b0;
            m_ticks = 0;
            for (int n = 0; n < N; n++) m_run[n] = 2;
        end else begin
            din   = cur_din();
            ev    = (m_rise & din & ~m_din_prev) | (m_fall & ~din & m_din_prev);
            irq_n = |(m_stat & m_en);
            clr   = '0;
            if (cyc && stb && (adr[31:6] == BASE[31:6]) && !m_ack) begin
                idx = adr[5:2];
                case (idx)
                    4'd0: rd = m_out;
                    4'd1: rd = m_oe;
                    4'd2: rd = din;
                    4'd3: rd = m_en;
                    4'd4: rd = m_rise;
                    4'd5: rd = m_fall;
                    4'd6: rd = m_stat;
`ifdef GPIO_DEBOUNCE_EN
                    4'd8: rd = m_byp;
`endif
                    default: rd = '0;
                endcase
                bm = bytes_of(sel) & MSK;
                wd = dat_w & bm;
                if (we) begin
                    case (idx)
                        4'd0: m_out  = (m_out & ~bm) | wd;
                        4'd1: m_oe   = (m_oe & ~bm) | wd;
                        4'd3: m_en   = (m_en & ~bm) | wd;
                        4'd4: m_rise = (m_rise & ~bm) | wd;
                        4'd5: m_fall = (m_fall & ~bm) | wd;
                        4'd6: clr    = wd;
                        4'd7: m_out  = m_out ^ wd;
`ifdef GPIO_DEBOUNCE_EN
                        4'd8: m_byp  = (m_byp & ~bm) | wd;
`endif
                        default: ;
                    endcase
                end
                m_ack = 1'b1;
                m_dat = rd;
            end else begin
                m_ack = 1'b0;
                m_dat = '0;
            end
            m_stat     = (m_stat & ~clr) | ev;
            m_irq      = irq_n;
            m_din_prev = din;
            m_ticks++;
            if (m_ticks % DIV == 0) begin
                for (int n = 0; n < N; n++) begin
                    if (m_pin_old[n] == m_last[n]) m_run[n]++;
                    else m_run[n] = 1;
                    m_last[n] = m_pin_old[n];
                    if (m_run[n] >= 3) m_db[n] = m_last[n];
                end
            end
            m_pin_old = m_pin_new;
            m_pin_new = 32'(gpio_in);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("gpio_out", 32'(gpio_out), m_out);
            check("gpio_oeb", 32'(gpio_oeb), ~m_oe & MSK);
            check("irq", 32'(irq), 32'(m_irq));
            check("ack", 32'(ack), 32'(m_ack));
            check("dat_o", dat_r, m_dat);
        end
    end

    // ------------------------------------------------------------------
    // Bus helpers
    // ------------------------------------------------------------------
    task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rdata);
        int n;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 8);
        if (!ack) check("bus_ack_timeout", 32'(ack), 32'd1);
        rdata = dat_r;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s = 4'hF);
        logic [31:0] dummy;
        xfer(BASE + off, 1'b1, s, d, dummy);
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] d);
        xfer(BASE + off, 1'b0, 4'hF, 32'h0, d);
    endtask

    logic [31:0] d;
    logic [N-1:0] flip;

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = '0; dat_w = '0; gpio_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        check("rst_gpio_out", 32'(gpio_out), 32'h00);
        check("rst_gpio_oeb", 32'(gpio_oeb), 32'hFF);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_dat_o", dat_r, 32'h0);
        for (int i = 0; i < 16; i++) begin
            rd(32'(i * 4), d);
            check($sformatf("rst_read_%02h", i * 4), d, 32'h0);
        end
`ifdef GPIO_DEBOUNCE_EN
        wr(32'h20, 32'hFF);
`endif

        // output data, enable, byte enables, toggle
        wr(32'h04, 32'h0F);
        wr(32'h00, 32'hA5, 4'b0001);
        check("out_a5", 32'(gpio_out), 32'hA5);
        check("oeb_f0", 32'(gpio_oeb), 32'hF0);
        wr(32'h1C, 32'hFF);
        check("toggle_5a", 32'(gpio_out), 32'h5A);
        wr(32'h00, 32'h0000_0033, 4'b0010);
        check("sel_masked", 32'(gpio_out), 32'h5A);
        rd(32'h1C, d);
        check("toggle_reads_0", d, 32'h0);

        // rising edge on pin 0: status at 3rd edge, irq at 4th
        wr(32'h10, 32'h01);
        wr(32'h0C, 32'h01);
        @(negedge clk);
        gpio_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("irq_before_4th", 32'(irq), 32'h0);
        @(negedge clk);
        check("irq_at_4th", 32'(irq), 32'h1);
        rd(32'h18, d);
        check("status_rise0", d, 32'h01);
        wr(32'h18, 32'h01);
        check("irq_ack_edge", 32'(irq), 32'h1);
        @(negedge clk);
        check("irq_cleared", 32'(irq), 32'h0);

        // falling edge on pin 3 with irq disabled
        wr(32'h14, 32'h08);
        wr(32'h0C, 32'h00);
        @(negedge clk);
        gpio_in[3] = 1'b1;
        repeat (5) @(negedge clk);
        gpio_in[3] = 1'b0;
        repeat (5) @(negedge clk);
        rd(32'h18, d);
        check("status_fall3", d, 32'h08);
        check("irq_masked", 32'(irq), 32'h0);
        wr(32'h0C, 32'h08);
        @(negedge clk);
        check("irq_enabled", 32'(irq), 32'h1);
        wr(32'h18, 32'hFF);

        // W1C coinciding with a rising edge on pin 2
        wr(32'h10, 32'h05);
        @(negedge clk);
        gpio_in[2] = 1'b1;
        @(negedge clk);
        wr(32'h18, 32'h04);
        rd(32'h18, d);
        check("set_wins", d, 32'h04);
        wr(32'h18, 32'h04);
        rd(32'h18, d);
        check("w1c_clears", d, 32'h00);

        // held strobe acks every second cycle
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE; sel = 4'hF;
        @(negedge clk); check("held_ack0", 32'(ack), 32'h1);
        @(negedge clk); check("held_ack1", 32'(ack), 32'h0);
        @(negedge clk); check("held_ack2", 32'(ack), 32'h1);
        @(negedge clk); check("held_ack3", 32'(ack), 32'h0);
        adr = BASE + 32'h40;
        @(negedge clk);
        @(negedge clk); check("other_block_no_ack", 32'(ack), 32'h0);
        cyc = 1'b0; stb = 1'b0;

        // reset during a write aborts it
        gpio_in = '0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h04; sel = 4'hF; dat_w = 32'hFF;
        rst = 1'b1;
        @(negedge clk);
        check("rst_abort_ack", 32'(ack), 32'h0);
        check("rst_abort_oeb", 32'(gpio_oeb), 32'hFF);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;

`ifdef GPIO_DEBOUNCE_EN
        // debounce: short glitch filtered, long level accepted
        repeat (16) @(negedge clk);
        gpio_in[1] = 1'b1;
        repeat (DIV) @(negedge clk);
        gpio_in[1] = 1'b0;
        repeat (16) @(negedge clk);
        rd(32'h08, d);
        check("dbnc_glitch", d, 32'h00);
        gpio_in[1] = 1'b1;
        repeat (20) @(negedge clk);
        rd(32'h08, d);
        check("dbnc_level", d, 32'h02);
        gpio_in = '0;
`endif

        // randomized traffic, pins and occasional resets
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 299) == 0);
            cyc   = ($urandom_range(0, 3) != 0);
            stb   = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            sel   = 4'($urandom_range(0, 15));
            dat_w = $urandom;
            adr   = ($urandom_range(0, 15) == 0) ? $urandom : (BASE | 32'($urandom_range(0, 63)));
            if ($urandom_range(0, 5) == 0) begin
                flip = '0;
                flip[$urandom_range(0, N - 1)] = 1'b1;
                gpio_in = gpio_in ^ flip;
            end
        end
        @(negedge clk);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_gpio_bank.md
WB_GPIO_BANK -- requirements
Module: wb_gpio_bank

Interface
REQ-001 SHALL have parameter NUM_GPIO, default 8, number of GPIO channels; legal range 1..32.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address; 64-byte aligned.
REQ-003 SHALL have parameter DBNC_DIV, default 1000, debounce tick divisor in clocks; legal range 2..65535; used only with GPIO_DEBOUNCE_EN.
REQ-004 SHALL use one clock and a synchronous, active-high reset: wb_clk_i and wb_rst_i.
REQ-005 SHALL have ports, one per line (name, direction, width, meaning):
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic slave controls
- wbs_sel_i  in  4  byte enables
- wbs_adr_i, wbs_dat_i  in  32 each  address, write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- gpio_in  in  NUM_GPIO  asynchronous pad inputs
- gpio_out  out  NUM_GPIO  pad output data
- gpio_oeb  out  NUM_GPIO  active-low pad output enable
- irq  out  1  level interrupt

Function
REQ-006 SHALL select the block when cyc&stb and wbs_adr_i[31:6]==BASE_ADDR[31:6]; register index is wbs_adr_i[5:2].
REQ-007 SHALL assert wbs_ack_o for exactly one cycle, one cycle after a selected request; it SHALL NOT ack in the cycle after an ack, so a held stb produces an ack every second cycle.
REQ-008 SHALL ack unselected offsets with read data 0 and ignore their writes.
REQ-009 SHALL apply writes only to bytes enabled by wbs_sel_i, committed on the ack cycle.
REQ-010 SHALL read register bits at or above NUM_GPIO as 0 and ignore writes to them.
REQ-011 Register map:
- 0x00 DATA_OUT  rw  drives gpio_out
- 0x04 OE  rw  gpio_oeb = ~OE
- 0x08 DATA_IN  ro
- 0x0C IRQ_EN  rw
- 0x10 IRQ_RISE  rw
- 0x14 IRQ_FALL  rw
- 0x18 IRQ_STATUS  W1C
- 0x1C OUT_TOGGLE  wo; XORs write data into DATA_OUT; reads 0
REQ-012 SHALL pass gpio_in through a 2-flop synchronizer; DATA_IN reflects a pin change at the 2nd rising clock edge after it.
REQ-013 SHALL register the previous DATA_IN. A 0->1 transition with IRQ_RISE[n]=1, or a 1->0 transition with IRQ_FALL[n]=1, SHALL set IRQ_STATUS[n] one edge after DATA_IN changes. Both bits set = both edges.
REQ-014 IRQ_STATUS bits SHALL set regardless of IRQ_EN.
REQ-015 irq SHALL be registered |(IRQ_STATUS & IRQ_EN), asserted one edge after the status bit sets.
REQ-016 If an edge event and a W1C of the same bit occur in the same cycle, set SHALL win.
REQ-017 Writes to IRQ_RISE/IRQ_FALL SHALL NOT create events; edges detected in the same cycle use the old values.

Reset
REQ-018 On wb_rst_i, all registers and synchronizer/previous flops SHALL clear at the next edge: gpio_out=0, gpio_oeb=all 1s, irq=0, wbs_ack_o=0, wbs_dat_o=0.
REQ-019 A reset asserted mid-transaction SHALL abort it: no ack, no register write.
REQ-020 The first sample after reset SHALL NOT generate an edge event (previous value is 0 and IRQ_RISE is 0).

Configuration
REQ-021 With GPIO_DEBOUNCE_EN defined:
- a free-running counter produces a tick every DBNC_DIV clocks;
- DATA_IN[n] updates only after the synchronized pin holds one value for 3 consecutive ticks;
- register 0x20 DBNC_BYPASS (rw, reset 0) makes bypassed pins behave as in REQ-012.
REQ-022 Without GPIO_DEBOUNCE_EN, no debounce logic exists, and offset 0x20 behaves per REQ-008.

Verification
REQ-023 Reset, then read all offsets: 0x04 reads 0, gpio_oeb=8'hFF, all others read 0.
REQ-024 Write OE=8'h0F, then DATA_OUT=8'hA5 with sel=4'b0001: gpio_out=8'hA5, gpio_oeb=8'hF0. Then write 0x1C=8'hFF: gpio_out=8'h5A.
REQ-025 IRQ_RISE=1, IRQ_EN=1, drive gpio_in[0] 0->1: IRQ_STATUS=1 on the 3rd edge, irq=1 on the 4th. Write 0x18=1: irq drops one edge later.
REQ-026 IRQ_FALL[3]=1, IRQ_EN=0, fall on pin 3: STATUS[3]=1, irq stays 0. Then set IRQ_EN[3]=1: irq=1.
REQ-027 W1C of bit 2 in the same cycle a rising edge on pin 2 is detected: STATUS[2] remains 1.
REQ-028 With GPIO_DEBOUNCE_EN and DBNC_DIV=4, a 1-tick glitch on pin 1: DATA_IN unchanged. A level held for 12+ clocks: DATA_IN updates.
